// File: rtl/freq_sweep_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// freq_sweep_ctrl : DDS tuning-word sweep controller (ramp/sawtooth/triangle)
// Revision 1.0
// ----------------------------------------------------------------------------
module freq_sweep_ctrl #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [31:0]        f_start,
  input  logic [31:0]        f_stop,
  input  logic [31:0]        f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [31:0]        freq_c,
  output logic               busy,
  output logic               step_stb,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        freq_q, freq_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [31:0]        f_start_q, f_start_d;
  logic [31:0]        f_stop_q, f_stop_d;
  logic [31:0]        f_step_q, f_step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               step_stb_q, step_stb_d;
  logic               done_q, done_d;
  logic               done_pend_q, done_pend_d;

  logic [32:0]        sum;
  logic [32:0]        diff;
  logic [31:0]        up_next;
  logic [31:0]        dn_next;
  logic               dwell_end;

  // Clamp on carry/borrow as well, so the word never wraps around.
  always_comb begin
    sum       = {1'b0, freq_q} + {1'b0, f_step_q};
    diff      = {1'b0, freq_q} - {1'b0, f_step_q};
    up_next   = (sum[32] || (sum[31:0] >= f_stop_q)) ? f_stop_q : sum[31:0];
    dn_next   = (diff[32] || (diff[31:0] <= f_start_q)) ? f_start_q : diff[31:0];
    dwell_end = (cnt_q == dwell_q);
  end

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    f_start_d   = f_start_q;
    f_stop_d    = f_stop_q;
    f_step_d    = f_step_q;
    dwell_d     = dwell_q;
    step_stb_d  = 1'b0;
    done_d      = done_pend_q && !stop;
    done_pend_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          mode_d     = mode;
          f_start_d  = f_start;
          f_stop_d   = f_stop;
          f_step_d   = f_step;
          dwell_d    = dwell;
          freq_d     = f_start;
          step_stb_d = 1'b1;
          cnt_d      = '0;
          if (mode != 2'b11) begin
            if ((f_step == 32'd0) || (f_stop <= f_start))
              done_pend_d = 1'b1;
            else
              state_d = S_UP;
          end
        end
      end

      S_UP: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (dwell_end) begin
          cnt_d = '0;
          if (freq_q == f_stop_q) begin
            case (mode_q)
              2'b01: begin
                freq_d     = f_start_q;
                step_stb_d = 1'b1;
              end
              2'b10: begin
                state_d    = S_DOWN;
                freq_d     = dn_next;
                step_stb_d = 1'b1;
              end
              default: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            endcase
          end else begin
            freq_d     = up_next;
            step_stb_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end

      S_DOWN: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (dwell_end) begin
          cnt_d      = '0;
          step_stb_d = 1'b1;
          if (freq_q == f_start_q) begin
            state_d = S_UP;
            freq_d  = up_next;
          end else begin
            freq_d  = dn_next;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      freq_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      f_step_q    <= '0;
      dwell_q     <= '0;
      step_stb_q  <= 1'b0;
      done_q      <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      f_start_q   <= f_start_d;
      f_stop_q    <= f_stop_d;
      f_step_q    <= f_step_d;
      dwell_q     <= dwell_d;
      step_stb_q  <= step_stb_d;
      done_q      <= done_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign freq_c   = freq_q;
  assign busy     = (state_q != S_IDLE);
  assign step_stb = step_stb_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_sweep_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_freq_sweep_ctrl : directed self-checking bench for freq_sweep_ctrl
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_freq_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [31:0] f_start;
  logic [31:0] f_stop;
  logic [31:0] f_step;
  logic [23:0] dwell;
  logic [31:0] freq_c;
  logic        busy;
  logic        step_stb;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int stb_cnt;
  int done_cnt;

  logic [31:0] exp_ramp  [5] = '{32'd1000, 32'd1250, 32'd1500, 32'd1750, 32'd2000};
  logic [31:0] exp_clamp [5] = '{32'd1000, 32'd1250, 32'd1500, 32'd1750, 32'd1900};
  logic [31:0] exp_tri   [9] = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd300,
                                 32'd200, 32'd100, 32'd200, 32'd300};
  logic [31:0] exp_carry [5] = '{32'hFFFF_FF00, 32'hFFFF_FF80, 32'hFFFF_FFFF,
                                 32'hFFFF_FF00, 32'hFFFF_FF80};

  freq_sweep_ctrl #(.DWELL_W(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .f_start  (f_start),
    .f_stop   (f_stop),
    .f_step   (f_step),
    .dwell    (dwell),
    .freq_c   (freq_c),
    .busy     (busy),
    .step_stb (step_stb),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_sweep(input logic [1:0] m, input logic [31:0] fs,
                             input logic [31:0] fe, input logic [31:0] fp,
                             input logic [23:0] dw);
    mode    = m;
    f_start = fs;
    f_stop  = fe;
    f_step  = fp;
    dwell   = dw;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic abort();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    #12;
    check("reset_freq", freq_c, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_stb",  {31'd0, step_stb}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single ramp, dwell 3
    start_sweep(2'b00, 32'd1000, 32'd2000, 32'd250, 24'd3);
    stb_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("ramp_freq[%0d]", i), freq_c, exp_ramp[i/4]);
      check($sformatf("ramp_busy[%0d]", i), {31'd0, busy}, 32'd1);
      stb_cnt  += int'(step_stb);
      done_cnt += int'(done);
      tick();
    end
    check("ramp_stb_count", stb_cnt, 32'd5);
    check("ramp_no_early_done", done_cnt, 32'd0);
    check("ramp_done", {31'd0, done}, 32'd1);
    check("ramp_end_busy", {31'd0, busy}, 32'd0);
    check("ramp_end_freq", freq_c, 32'd2000);
    tick();
    check("ramp_done_pulse", {31'd0, done}, 32'd0);

    // Clamped last step
    start_sweep(2'b00, 32'd1000, 32'd1900, 32'd250, 24'd3);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("clamp_freq[%0d]", i), freq_c, exp_clamp[i/4]);
      tick();
    end
    check("clamp_done", {31'd0, done}, 32'd1);
    check("clamp_end_freq", freq_c, 32'd1900);
    tick();

    // Triangle, dwell 0
    start_sweep(2'b10, 32'd100, 32'd400, 32'd100, 24'd0);
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("tri_freq[%0d]", i), freq_c, exp_tri[i]);
      check($sformatf("tri_busy[%0d]", i), {31'd0, busy}, 32'd1);
      check($sformatf("tri_stb[%0d]", i), {31'd0, step_stb}, 32'd1);
      done_cnt += int'(done);
      tick();
    end
    check("tri_no_done", done_cnt, 32'd0);
    abort();

    // Sawtooth with carry clamp
    start_sweep(2'b01, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("carry_freq[%0d]", i), freq_c, exp_carry[i]);
      tick();
    end
    abort();

    // Abort mid-ramp at 1500
    start_sweep(2'b00, 32'd1000, 32'd2000, 32'd250, 24'd3);
    repeat (8) tick();
    check("abort_pre_freq", freq_c, 32'd1500);
    abort();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_freq", freq_c, 32'd1500);
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      done_cnt += int'(done);
      tick();
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_hold_freq", freq_c, 32'd1500);

    // start and stop together in IDLE
    mode = 2'b00; f_start = 32'd7; f_stop = 32'd99; f_step = 32'd1; dwell = 24'd0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_freq", freq_c, 32'd1500);
    check("startstop_busy", {31'd0, busy}, 32'd0);
    check("startstop_stb",  {31'd0, step_stb}, 32'd0);

    // start while busy is ignored
    start_sweep(2'b00, 32'd1000, 32'd2000, 32'd250, 24'd3);
    tick(); tick();
    start_sweep(2'b00, 32'd7, 32'd99, 32'd1, 24'd0);
    check("busy_start_freq0", freq_c, 32'd1000);
    tick();
    check("busy_start_freq1", freq_c, 32'd1250);
    check("busy_start_stb",   {31'd0, step_stb}, 32'd1);
    abort();

    // Degenerate: zero step
    start_sweep(2'b00, 32'd3000, 32'd4000, 32'd0, 24'd3);
    check("zstep_freq", freq_c, 32'd3000);
    check("zstep_stb",  {31'd0, step_stb}, 32'd1);
    check("zstep_busy", {31'd0, busy}, 32'd0);
    check("zstep_done0", {31'd0, done}, 32'd0);
    tick();
    check("zstep_done1", {31'd0, done}, 32'd1);
    check("zstep_stb1",  {31'd0, step_stb}, 32'd0);
    tick();
    check("zstep_done2", {31'd0, done}, 32'd0);

    // Degenerate: stop word equal to start word
    start_sweep(2'b01, 32'd500, 32'd500, 32'd10, 24'd0);
    check("eqstop_busy", {31'd0, busy}, 32'd0);
    tick();
    check("eqstop_done", {31'd0, done}, 32'd1);
    tick();

    // Fixed frequency
    start_sweep(2'b11, 32'd4242, 32'd9999, 32'd10, 24'd0);
    check("fixed_freq", freq_c, 32'd4242);
    check("fixed_busy", {31'd0, busy}, 32'd0);
    check("fixed_stb",  {31'd0, step_stb}, 32'd1);
    tick();
    check("fixed_done", {31'd0, done}, 32'd0);
    tick();
    check("fixed_hold", freq_c, 32'd4242);

    // Asynchronous reset mid-sweep
    start_sweep(2'b10, 32'd100, 32'd400, 32'd100, 24'd0);
    tick(); tick();
    check("rst_pre_freq", freq_c, 32'd300);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_freq", freq_c, 32'd0);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    check("rst_async_stb",  {31'd0, step_stb}, 32'd0);
    check("rst_async_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_idle_freq", freq_c, 32'd0);
    check("rst_idle_done", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
